// File: rtl/seg7_scan_driver_if.sv
// Bus between the display datapath (master) and the 7-segment scan driver (slave).
// load is a 1-cycle strobe with no back-pressure: value is captured on every clock where load is high.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output value, load, digit_en,
        input  seg, an, frame_tick
    );

    modport slave (
        input  value, load, digit_en,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver with tear-free value updates at frame boundaries.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int PRESCALE       = 1000,
    parameter bit ACTIVE_LOW_SEG = 1'b1,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input logic          clk,
    input logic          rst,
    seg7_scan_driver_if.slave bus
);
    localparam int PS_W  = $clog2(PRESCALE);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    logic [PS_W-1:0]       ps_q, ps_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  ft_q, ft_d;

    logic                  slot_end;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] show;
    logic                  zero_above;
    logic [3:0]            nib;
    logic                  cur_en;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [6:0]            seg_on;

    function automatic logic [6:0] seg7_lit(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (ps_q == PS_W'(PRESCALE - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Scan counters and the pending/displayed value pair.
    always_comb begin
        ps_d        = slot_end ? '0 : ps_q + PS_W'(1);
        idx_d       = idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_flag_d = pend_flag_q;
        if (slot_end) begin
            idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_end) begin
            if (bus.load) begin
                disp_d = bus.value;
            end else if (pend_flag_q) begin
                disp_d = pend_q;
            end
            pend_flag_d = 1'b0;
        end else if (bus.load) begin
            pend_d      = bus.value;
            pend_flag_d = 1'b1;
        end
    end

    // Walk down from the top digit so a digit is blanked only if it and everything above is zero.
    always_comb begin
        show       = bus.digit_en;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
`ifdef SEG7_LZB_EN
            if (i > 0 && zero_above) begin
                show[i] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        nib    = 4'd0;
        cur_en = 1'b0;
        an_hot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = disp_q[4*i +: 4];
                cur_en    = show[i];
                an_hot[i] = 1'b1;
            end
        end
        seg_on = cur_en ? seg7_lit(nib) : 7'd0;
        // First cycle of every slot keeps all anodes off so the previous digit cannot ghost.
        an_d   = ((cur_en && ps_q != '0) ? an_hot : '0) ^ {NUM_DIGITS{ACTIVE_LOW_AN}};
        seg_d  = seg_on ^ {7{ACTIVE_LOW_SEG}};
        ft_d   = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q        <= '0;
            idx_q       <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= {7{ACTIVE_LOW_SEG}};
            an_q        <= {NUM_DIGITS{ACTIVE_LOW_AN}};
            ft_q        <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            ft_q        <= ft_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, prescale 4, active-low segments and anodes.
// Expected active slots go into a queue; a negedge monitor compares them as the display scans.
module tb_seg7_scan_driver;
    logic clk;
    logic rst;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS    (4),
        .PRESCALE      (4),
        .ACTIVE_LOW_SEG(1'b1),
        .ACTIVE_LOW_AN (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Active-low gfedcba codes for nibbles 0..F.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [10:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    bit was_active = 1'b0;
    bit ft_seen = 1'b0;
    int since_ft = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full frame (16 edges). Expected slots are queued first; loads fire at edge offsets la/lb (0 = none).
    task automatic run_frame(input logic [15:0] shown, input logic [3:0] en, input logic [3:0] mask,
                             input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
        logic [3:0] an_e;
        for (int i = 0; i < 4; i++) begin
            if (en[i]) begin
                an_e    = 4'hF;
                an_e[i] = 1'b0;
                exp_q.push_back({an_e, seg_tab[shown[4*i +: 4]]});
            end
        end
        bus.digit_en = mask;
        for (int k = 1; k <= 16; k++) begin
            bus.load = (k == la) || (k == lb);
            if (k == la) bus.value = va;
            if (k == lb) bus.value = vb;
            tick();
            bus.load = 1'b0;
            check("frame_tick", {31'd0, bus.frame_tick}, {31'd0, k == 16});
            if (k % 4 == 1) begin
                check("ghost_blank", {28'd0, bus.an}, 32'hF);
            end else if (!en[(k-2)/4]) begin
                check("masked_an", {28'd0, bus.an}, 32'hF);
                check("masked_seg", {25'd0, bus.seg}, 32'h7F);
            end
        end
    endtask

    // Monitor: holds the head entry across a digit's active cycles, pops when anodes go dark.
    always @(negedge clk) begin
        if (rst) begin
            was_active = 1'b0;
            ft_seen    = 1'b0;
        end else begin
            if (bus.frame_tick) begin
                if (ft_seen) check("frame_period", since_ft, 16);
                ft_seen  = 1'b1;
                since_ft = 0;
            end
            since_ft++;
            if (bus.an != 4'hF) begin
                if (exp_q.size() == 0) check("unexpected_slot", {21'd0, bus.an, bus.seg}, 32'h7FF);
                else check("slot", {21'd0, bus.an, bus.seg}, {21'd0, exp_q[0]});
                was_active = 1'b1;
            end else if (was_active) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                was_active = 1'b0;
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.digit_en = 4'hF;
        repeat (3) tick();
        check("rst_an", {28'd0, bus.an}, 32'hF);
        check("rst_seg", {25'd0, bus.seg}, 32'h7F);
        check("rst_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst = 1'b0;

        run_frame(16'h0000, LZB ? 4'h1 : 4'hF, 4'hF, 16, 16'h1A3F, 0, 16'h0);
        run_frame(16'h1A3F, 4'hF, 4'hF, 5, 16'h0123, 0, 16'h0);
        run_frame(16'h0123, LZB ? 4'h7 : 4'hF, 4'hF, 9, 16'h4567, 0, 16'h0);
        run_frame(16'h4567, 4'hF, 4'hF, 16, 16'h89AB, 0, 16'h0);
        run_frame(16'h89AB, 4'hF, 4'hF, 1, 16'hCDEF, 0, 16'h0);
        run_frame(16'hCDEF, 4'hF, 4'hF, 2, 16'h1111, 0, 16'h0);
        run_frame(16'h1111, 4'hF, 4'hF, 7, 16'h2222, 0, 16'h0);
        run_frame(16'h2222, 4'hF, 4'hF, 4, 16'h3333, 12, 16'h4444);
        run_frame(16'h4444, 4'hF, 4'hF, 8, 16'h5555, 16, 16'h6666);
        run_frame(16'h6666, 4'hF, 4'hF, 0, 16'h0, 0, 16'h0);
        run_frame(16'h6666, 4'h5, 4'h5, 3, 16'h0042, 0, 16'h0);
        run_frame(16'h0042, LZB ? 4'h3 : 4'hF, 4'hF, 10, 16'h0000, 0, 16'h0);
        run_frame(16'h0000, LZB ? 4'h1 : 4'hF, 4'hF, 16, 16'h7777, 0, 16'h0);

        // Mid-scan reset with a pending value: both the shown and pending words must be lost.
        bus.digit_en = 4'h0;
        tick();
        bus.value = 16'h9999;
        bus.load  = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_an", {28'd0, bus.an}, 32'hF);
        check("midrst_seg", {25'd0, bus.seg}, 32'h7F);
        check("midrst_tick", {31'd0, bus.frame_tick}, 32'd0);
        rst = 1'b0;
        run_frame(16'h0000, LZB ? 4'h1 : 4'hF, 4'hF, 0, 16'h0, 0, 16'h0);
        run_frame(16'h0000, LZB ? 4'h1 : 4'hF, 4'hF, 0, 16'h0, 0, 16'h0);

        repeat (2) tick();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
